// File: rtl/inv_sub_bytes_iter.sv
// rtl/inv_sub_bytes_iter.sv - iterative AES inverse S-box stage, BYTES_PER_CYCLE lanes per clock
// Optional INV_SUB_BYTES_BYPASS_EN adds a bypass input that passes blocks through unsubstituted.
module inv_sub_bytes_iter #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [0:127] in_state,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [0:127] out_state,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef INV_SUB_BYTES_BYPASS_EN
    input  logic         bypass,
`endif
    output logic         busy
);

    localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
    localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PROC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [0:127]       work_q, work_d;
    logic [0:127]       out_state_q, out_state_d;
    logic               bypass_q;
    logic               accept;

    logic [6:0]         lane_off [BYTES_PER_CYCLE];
    logic [7:0]         lane_in  [BYTES_PER_CYCLE];
    logic [7:0]         lane_out [BYTES_PER_CYCLE];

`ifdef INV_SUB_BYTES_BYPASS_EN
    logic               bypass_d;
`else
    assign bypass_q = 1'b0;
`endif

    // Lane l of step c works on byte c*B+l; the LUTs are shared across all steps.
    always_comb begin
        for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
            lane_off[l] = 7'((int'(cnt_q) * BYTES_PER_CYCLE + l) * 8);
            lane_in[l]  = work_q[lane_off[l] +: 8];
            lane_out[l] = bypass_q ? lane_in[l] : INV_SBOX[lane_in[l]];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        out_state_d = out_state_q;
`ifdef INV_SUB_BYTES_BYPASS_EN
        bypass_d    = bypass_q;
`endif
        in_ready    = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_PROC: begin
                for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
                    work_d[lane_off[l] +: 8] = lane_out[l];
                end
                if (cnt_q == LAST_STEP) begin
                    out_state_d = work_d;
                    cnt_d       = '0;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                // Ready passes straight through so a new block can load on the drain edge.
                in_ready = out_ready;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        accept = in_valid && in_ready;
        if (accept) begin
            work_d  = in_state;
            cnt_d   = '0;
            state_d = S_PROC;
`ifdef INV_SUB_BYTES_BYPASS_EN
            bypass_d = bypass;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_state_q <= '0;
`ifdef INV_SUB_BYTES_BYPASS_EN
            bypass_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            out_state_q <= out_state_d;
`ifdef INV_SUB_BYTES_BYPASS_EN
            bypass_q    <= bypass_d;
`endif
        end
    end

    assign out_state = out_state_q;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_PROC);

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb/tb_inv_sub_bytes_iter.sv - directed vector bench for inv_sub_bytes_iter (4-lane and 1-lane builds)
module tb_inv_sub_bytes_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [0:127] a_in, a_out, b_in, b_out;
    logic         a_iv, a_ir, a_ov, a_or, a_busy;
    logic         b_iv, b_ir, b_ov, b_or, b_busy;
`ifdef INV_SUB_BYTES_BYPASS_EN
    logic         a_byp, b_byp;
`endif

    int total = 0;
    int bad   = 0;

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(4)) dut_a (
        .clk(clk), .reset(reset),
        .in_state(a_in), .in_valid(a_iv), .in_ready(a_ir),
        .out_state(a_out), .out_valid(a_ov), .out_ready(a_or),
`ifdef INV_SUB_BYTES_BYPASS_EN
        .bypass(a_byp),
`endif
        .busy(a_busy)
    );

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1)) dut_b (
        .clk(clk), .reset(reset),
        .in_state(b_in), .in_valid(b_iv), .in_ready(b_ir),
        .out_state(b_out), .out_valid(b_ov), .out_ready(b_or),
`ifdef INV_SUB_BYTES_BYPASS_EN
        .bypass(b_byp),
`endif
        .busy(b_busy)
    );

    typedef struct {
        logic [0:127] din;
        logic [0:127] dout;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    task automatic a_send(input logic [0:127] d, output int lat);
        int n;
        n = 0;
        while (!a_ir && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) timeout("a_in_ready");
        a_in = d;
        a_iv = 1'b1;
        @(posedge clk); #1;
        a_iv = 1'b0;
        lat = 0;
        while (!a_ov && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 40) timeout("a_out_valid");
    endtask

    task automatic b_send(input logic [0:127] d, output int lat);
        int n;
        n = 0;
        while (!b_ir && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) timeout("b_in_ready");
        b_in = d;
        b_iv = 1'b1;
        @(posedge clk); #1;
        b_iv = 1'b0;
        lat = 0;
        while (!b_ov && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 40) timeout("b_out_valid");
    endtask

    localparam logic [0:127] V1_IN  = 128'h00637c16_00637c16_00637c16_00637c16;
    localparam logic [0:127] V1_OUT = 128'h520001ff_520001ff_520001ff_520001ff;
    localparam logic [0:127] V3_IN  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] V3_OUT = 128'h52096ad53036a538bf40a39e81f3d7fb;

    initial begin
        int lat;
        int n;

        tbl[0] = '{V1_IN, V1_OUT};
        tbl[1] = '{128'hffffffff_ffffffff_ffffffff_ffffffff, 128'h7d7d7d7d_7d7d7d7d_7d7d7d7d_7d7d7d7d};
        tbl[2] = '{V3_IN, V3_OUT};
        tbl[3] = '{128'h101112131415161718191a1b1c1d1e1f, 128'h7ce339829b2fff87348e4344c4dee9cb};
        tbl[4] = '{128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 128'h172b047eba77d626e169146355210c7d};
        tbl[5] = '{128'h0, 128'h52525252_52525252_52525252_52525252};
        tbl[6] = '{128'h08182838485868788898a8b8c8d8e8f8, 128'hbf34ee76d45ef7c197e26f9ab12dc8e1};

        reset = 1'b0;
        a_in = '1; a_iv = 1'b0; a_or = 1'b1;
        b_in = '1; b_iv = 1'b0; b_or = 1'b1;
`ifdef INV_SUB_BYTES_BYPASS_EN
        a_byp = 1'b0; b_byp = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", a_ir, 1'b1);
        check("rst_out_valid", a_ov, 1'b0);
        check("rst_out_state", a_out, 128'h0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_b_out_valid", b_ov, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            a_send(tbl[i].din, lat);
            check($sformatf("vec%0d_latency", i), lat, 4);
            check($sformatf("vec%0d_out_state", i), a_out, tbl[i].dout);
            @(posedge clk); #1;
            check($sformatf("vec%0d_drained", i), a_ov, 1'b0);
        end

        // Backpressure in DONE, then drain-and-accept on the same edge.
        a_or = 1'b0;
        a_send(V1_IN, lat);
        check("hold_latency", lat, 4);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d_out_valid", k), a_ov, 1'b1);
            check($sformatf("hold%0d_out_state", k), a_out, V1_OUT);
            check($sformatf("hold%0d_in_ready", k), a_ir, 1'b0);
        end
        a_in = V3_IN;
        a_iv = 1'b1;
        a_or = 1'b1;
        #1;
        check("bypass_ready", a_ir, 1'b1);
        @(posedge clk); #1;
        check("reaccept_busy", a_busy, 1'b1);
        check("reaccept_out_valid", a_ov, 1'b0);
        check("reaccept_in_ready", a_ir, 1'b0);
        check("reaccept_out_held", a_out, V1_OUT);
        a_in = '1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_iv = 1'b0;
        n = 2;
        while (!a_ov && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) timeout("reaccept_out_valid");
        check("reaccept_latency", n, 4);
        check("reaccept_out_state", a_out, V3_OUT);
        @(posedge clk); #1;

        // 1-lane instance: sixteen steps per block.
        b_send(128'hffffffff_ffffffff_ffffffff_ffffffff, lat);
        check("b_latency", lat, 16);
        check("b_out_state_ff", b_out, 128'h7d7d7d7d_7d7d7d7d_7d7d7d7d_7d7d7d7d);
        @(posedge clk); #1;
        b_send(V3_IN, lat);
        check("b_latency2", lat, 16);
        check("b_out_state_seq", b_out, V3_OUT);
        @(posedge clk); #1;

        // Reset two cycles into PROC.
        a_in = tbl[1].din;
        a_iv = 1'b1;
        @(posedge clk); #1;
        a_iv = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("midrst_busy", a_busy, 1'b0);
        check("midrst_out_valid", a_ov, 1'b0);
        check("midrst_in_ready", a_ir, 1'b1);
        check("midrst_out_state", a_out, 128'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        a_send(tbl[3].din, lat);
        check("postrst_latency", lat, 4);
        check("postrst_out_state", a_out, tbl[3].dout);
        @(posedge clk); #1;

        // Reset while a result waits in DONE.
        a_or = 1'b0;
        a_send(tbl[4].din, lat);
        check("donerst_pre_valid", a_ov, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("donerst_out_valid", a_ov, 1'b0);
        check("donerst_out_state", a_out, 128'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        a_or = 1'b1;
        @(posedge clk); #1;

`ifdef INV_SUB_BYTES_BYPASS_EN
        a_byp = 1'b1;
        a_in = 128'h216242c6db17a2abe6388d1dfa3c6260;
        a_iv = 1'b1;
        @(posedge clk); #1;
        a_iv = 1'b0;
        a_byp = 1'b0;
        n = 0;
        while (!a_ov && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) timeout("byp_out_valid");
        check("byp_latency", n, 4);
        check("byp_out_state", a_out, 128'h216242c6db17a2abe6388d1dfa3c6260);
        @(posedge clk); #1;
        a_send(128'h216242c6db17a2abe6388d1dfa3c6260, lat);
        check("nobyp_out_state", a_out, 128'h7babf6c79f871a0ef576b4de146dab90);
        @(posedge clk); #1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
